fifo_sum_reader: RTL and testbench

Read-side consumer for the show-ahead operand FIFO in the adder datapath. It pops operands from the FIFO whenever the FIFO is non-empty and accumulates them into groups of COUNT_N operands. Each group's sum is presented on a valid/ready output port for the downstream adder stage. A flush input closes a partial group early.

---
 rtl/fifo_sum_reader.sv | 84 ++++++++
 tb/tb_fifo_sum_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sum_reader.sv
// Read-side consumer for the show-ahead operand FIFO: pops operands, sums them
// in groups of COUNT_N (or shorter on flush), and presents each sum on a valid/ready port.
module fifo_sum_reader #(
  parameter int DATAW   = 8,
  parameter int COUNT_N = 4,
  parameter int SUMW    = DATAW + 4,
  parameter int LENW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DATAW-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_r,
  input  logic             flush,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [SUMW-1:0]  sum_data,
  output logic [LENW-1:0]  sum_len
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [LENW-1:0] LAST = LENW'(COUNT_N - 1);
  localparam logic [LENW-1:0] ONE  = LENW'(1);

  state_t          state;
  logic [SUMW-1:0] acc;
  logic [LENW-1:0] cnt;
  logic [SUMW-1:0] acc_next;

  // Unsigned accumulate; wraps modulo 2^SUMW, which legal parameters never reach.
  function automatic logic [SUMW-1:0] acc_add(input logic [SUMW-1:0] a,
                                               input logic [DATAW-1:0] d);
    acc_add = a + {{(SUMW-DATAW){1'b0}}, d};
  endfunction

  assign fifo_r   = rst & (state == ACC) & ~fifo_empty;
  assign acc_next = acc_add(acc, fifo_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      sum_valid <= 1'b0;
      sum_data  <= '0;
      sum_len   <= '0;
    end else begin
      case (state)
        ACC: begin
          if (fifo_r) begin
            if (cnt == LAST || flush) begin
              // Popped word closes the group (full, or flushed early).
              sum_data  <= acc_next;
              sum_len   <= cnt + ONE;
              sum_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              state     <= HOLD;
            end else begin
              acc <= acc_next;
              cnt <= cnt + ONE;
            end
          end else if (flush && cnt != '0) begin
            sum_data  <= acc;
            sum_len   <= cnt;
            sum_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (sum_ready) begin
            sum_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sum_reader.sv
// Bench for fifo_sum_reader: queue-based FIFO, group-level reference model checked
// every cycle, plus literal expectations on each accepted group.
module tb_fifo_sum_reader;

  localparam int DATAW   = 8;
  localparam int COUNT_N = 4;
  localparam int SUMW    = DATAW + 4;
  localparam int LENW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [DATAW-1:0] fifo_data;
  logic             fifo_empty;
  logic             fifo_r;
  logic             flush;
  logic             sum_valid;
  logic             sum_ready;
  logic [SUMW-1:0]  sum_data;
  logic [LENW-1:0]  sum_len;

  fifo_sum_reader #(.DATAW(DATAW), .COUNT_N(COUNT_N), .SUMW(SUMW), .LENW(LENW)) dut (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_r(fifo_r), .flush(flush), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .sum_data(sum_data), .sum_len(sum_len)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Bench-side FIFO contents
  int fq[$];
  bit pop_req = 1'b0;

  // Reference model: operands of the open group, plus the presented result
  int  grp[$];
  bit  m_hold, m_valid;
  int  m_data, m_len;
  int  mq_data[$], mq_len[$];
  int  got_data[$], got_len[$];

  task automatic model_reset();
    grp.delete();
    m_hold = 0; m_valid = 0; m_data = 0; m_len = 0;
  endtask

  task automatic model_close();
    int s = 0;
    foreach (grp[i]) s += grp[i];
    m_data  = s % (1 << SUMW);
    m_len   = grp.size();
    m_valid = 1; m_hold = 1;
    grp.delete();
  endtask

  initial model_reset();

  always @(negedge clk) begin
    bit m_pop;
    if (!rst) model_reset();
    chk("fifo_r",    fifo_r,    int'(rst && !m_hold && !fifo_empty));
    chk("sum_valid", sum_valid, m_valid);
    chk("sum_data",  sum_data,  m_data);
    chk("sum_len",   sum_len,   m_len);
    if (rst && sum_valid && sum_ready) begin
      got_data.push_back(sum_data);
      got_len.push_back(sum_len);
    end
    m_pop = rst && !m_hold && !fifo_empty;
    pop_req = m_pop;
    if (rst) begin
      if (!m_hold) begin
        if (m_pop) begin
          grp.push_back(int'(fifo_data));
          if (grp.size() == COUNT_N || flush) model_close();
        end else if (flush && grp.size() > 0) begin
          model_close();
        end
      end else if (sum_ready) begin
        mq_data.push_back(m_data);
        mq_len.push_back(m_len);
        m_valid = 0; m_hold = 0;
      end
    end
  end

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? '0 : DATAW'(fq[0]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pop_req && fq.size() > 0) void'(fq.pop_front());
    drive_fifo();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!sum_valid && k < 30) begin step(); k++; end
    if (!sum_valid) begin
      nvec++; nerr++;
      $display("FAIL %s: sum_valid never rose within 30 cycles", name);
    end
  endtask

  task automatic expect_group(input string name, input int d, input int l);
    if (got_data.size() == 0) begin
      nvec++; nerr++;
      $display("FAIL %s: no group accepted from DUT, expected sum %0d len %0d", name, d, l);
    end else begin
      chk({name, "_dut_sum"}, got_data.pop_front(), d);
      chk({name, "_dut_len"}, got_len.pop_front(), l);
    end
    if (mq_data.size() == 0) begin
      nvec++; nerr++;
      $display("FAIL %s: model produced no group, expected sum %0d len %0d", name, d, l);
    end else begin
      chk({name, "_model_sum"}, mq_data.pop_front(), d);
      chk({name, "_model_len"}, mq_len.pop_front(), l);
    end
  endtask

  initial begin
    int ops[4]  = '{2, 4, 6, 8};
    int gaps[4] = '{1, 2, 3, 0};

    // Reset with a non-empty FIFO
    rst = 1'b0; flush = 1'b0; sum_ready = 1'b1;
    fq = '{1, 2, 3, 4};
    drive_fifo();
    run(3);
    chk("rst_fifo_r", fifo_r, 0);
    chk("rst_valid", sum_valid, 0);
    chk("rst_data", sum_data, 0);
    chk("rst_len", sum_len, 0);
    step();
    rst = 1'b1;
    #1;
    chk("first_pop", fifo_r, 1);

    // Full group 1..4
    run(6);
    expect_group("full", 10, 4);

    // Backpressure on 5..8, then 9 pops after accept
    sum_ready = 1'b0;
    fq = '{5, 6, 7, 8, 9};
    drive_fifo();
    wait_valid("bp");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_no_pop", fifo_r, 0);
      chk("bp_stable", sum_data, 26);
    end
    sum_ready = 1'b1;
    step();
    chk("bp_pop9", fifo_r, 1);
    step();
    chk("bp_fifo_drained", fq.size(), 0);
    flush = 1'b1; step(); flush = 1'b0;
    run(2);
    expect_group("bp", 26, 4);
    expect_group("single9", 9, 1);

    // Maximum operands
    fq = '{255, 255, 255, 255};
    drive_fifo();
    run(7);
    expect_group("max", 1020, 4);

    // Flush with FIFO empty after two pops
    fq = '{7, 8};
    drive_fifo();
    run(3);
    flush = 1'b1; step(); flush = 1'b0;
    run(2);
    expect_group("flush_idle", 15, 2);

    // Flush on the same edge that pops 9
    fq.push_back(1);
    drive_fifo();
    step();
    fq.push_back(9);
    drive_fifo();
    flush = 1'b1; step(); flush = 1'b0;
    run(2);
    expect_group("flush_pop", 10, 2);

    // Flush with nothing accumulated
    flush = 1'b1; step(); flush = 1'b0;
    run(3);
    chk("flush_empty_dut", got_data.size(), 0);
    chk("flush_empty_model", mq_data.size(), 0);

    // Operands separated by empty cycles
    for (int i = 0; i < 4; i++) begin
      fq.push_back(ops[i]);
      drive_fifo();
      step();
      run(gaps[i]);
    end
    run(2);
    expect_group("gaps", 20, 4);

    // Reset while holding a result
    sum_ready = 1'b0;
    fq = '{3, 3, 3, 3};
    drive_fifo();
    wait_valid("pre_rst");
    #2 rst = 1'b0;
    #1;
    chk("rst_hold_valid", sum_valid, 0);
    chk("rst_hold_data", sum_data, 0);
    chk("rst_hold_fifo_r", fifo_r, 0);
    step();
    rst = 1'b1;
    sum_ready = 1'b1;
    fq = '{1, 2, 3, 4};
    drive_fifo();
    run(7);
    expect_group("after_rst", 10, 4);
    chk("leftover_dut", got_data.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
